// File: rtl/ras_hint_decode_if.sv
// rtl/ras_hint_decode_if.sv - handshake and decoded-field bundle for ras_hint_decode
interface ras_hint_decode_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [1:0]      out_ras_op;
  logic            out_illegal;
  logic            ras_en;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_imm, out_pc,
           out_ras_op, out_illegal, ras_en
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_imm, out_pc,
           out_ras_op, out_illegal, ras_en
  );
endinterface

// File: rtl/ras_hint_decode.sv
// rtl/ras_hint_decode.sv - JAL/JALR decode with RAS hint classification, output reg + skid
module ras_hint_decode #(
  parameter int         XLEN   = 32,
  parameter logic [4:0] LINK_A = 5'd1,
  parameter logic [4:0] LINK_B = 5'd5
) (
  input logic               clk,
  input logic               rst_n,
  ras_hint_decode_if.slave  bus
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    RAS_NONE     = 2'd0,
    RAS_PUSH     = 2'd1,
    RAS_POP      = 2'd2,
    RAS_POP_PUSH = 2'd3
  } ras_op_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    ras_op_e         ras_op;
    logic            illegal;
  } entry_t;

  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;

  entry_t w_dec;
  logic   w_lk_rd;
  logic   w_lk_rs1;
  logic   w_accept;
  logic   w_consume;

  always_comb begin
    w_dec         = '0;
    w_dec.opcode  = bus.in_instr[6:0];
    w_dec.rd      = bus.in_instr[11:7];
    w_dec.rs1     = bus.in_instr[19:15];
    w_dec.pc      = bus.in_pc;
    w_dec.illegal = (bus.in_instr[1:0] != 2'b11);
    w_dec.ras_op  = RAS_NONE;
    w_lk_rd       = (w_dec.rd == LINK_A) || (w_dec.rd == LINK_B);
    w_lk_rs1      = (w_dec.rs1 == LINK_A) || (w_dec.rs1 == LINK_B);
    if (!w_dec.illegal) begin
      if (w_dec.opcode == OP_JAL) begin
        w_dec.imm    = {{(XLEN-20){bus.in_instr[31]}}, bus.in_instr[19:12],
                        bus.in_instr[20], bus.in_instr[30:21], 1'b0};
        w_dec.ras_op = w_lk_rd ? RAS_PUSH : RAS_NONE;
      end else if (w_dec.opcode == OP_JALR) begin
        w_dec.imm = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        // Same link reg in rd and rs1 is a plain call (push only), not a coroutine swap.
        case ({w_lk_rd, w_lk_rs1})
          2'b01:   w_dec.ras_op = RAS_POP;
          2'b10:   w_dec.ras_op = RAS_PUSH;
          2'b11:   w_dec.ras_op = (w_dec.rd == w_dec.rs1) ? RAS_PUSH : RAS_POP_PUSH;
          default: w_dec.ras_op = RAS_NONE;
        endcase
      end
    end
  end

  assign w_accept  = bus.in_valid && !r_skid_valid;
  assign w_consume = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_consume) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out <= w_dec;
        end
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = !r_skid_valid;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_opcode  = r_out.opcode;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_pc      = r_out.pc;
  assign bus.out_ras_op  = r_out.ras_op;
  assign bus.out_illegal = r_out.illegal;
  assign bus.ras_en      = w_consume && (r_out.ras_op != RAS_NONE);
endmodule

// File: tb/tb_ras_hint_decode.sv
// tb/tb_ras_hint_decode.sv - directed and randomized checks of ras_hint_decode against a queue model
module tb_ras_hint_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ras_hint_decode_if #(.XLEN(32)) bus ();

  ras_hint_decode #(.XLEN(32), .LINK_A(5'd1), .LINK_B(5'd5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [1:0]  ras;
    logic        ill;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit lk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic ent_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
    ent_t e;
    logic [20:0] jv;
    logic [11:0] iv;
    int v;
    e.op = w[6:0]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.pc = pc;
    e.ill = (w[1:0] != 2'b11);
    e.imm = 0; e.ras = 0;
    jv = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    iv = w[31:20];
    if (!e.ill && e.op == 7'b1101111) begin
      v = int'(jv) - (jv[20] ? (1 << 21) : 0);
      e.imm = v;
      e.ras = lk(e.rd) ? 2'd1 : 2'd0;
    end else if (!e.ill && e.op == 7'b1100111) begin
      v = int'(iv) - (iv[11] ? 4096 : 0);
      e.imm = v;
      if (!lk(e.rd) && !lk(e.rs1))     e.ras = 2'd0;
      else if (!lk(e.rd))              e.ras = 2'd2;
      else if (!lk(e.rs1))             e.ras = 2'd1;
      else if (e.rd == e.rs1)          e.ras = 2'd1;
      else                             e.ras = 2'd3;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [4:0] regs [4];
    w = $urandom;
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'($urandom);
    w[11:7]  = regs[$urandom_range(0, 3)];
    w[19:15] = regs[$urandom_range(0, 3)];
    case ($urandom_range(0, 4))
      0: w[6:0] = 7'b1101111;
      1: w[6:0] = 7'b1100111;
      2: w[1:0] = 2'b11;
      3: begin w[6:0] = 7'b1101111; w[1:0] = 2'($urandom_range(0, 2)); end
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] d_instr [6];
  logic [1:0]  d_ras   [6];
  logic [31:0] d_imm   [6];
  logic        d_ill   [6];

  initial begin
    bit          acc, cons, exp_rdy;
    logic [31:0] pc_run;

    d_instr[0] = 32'h008000EF; d_ras[0] = 2'd1; d_imm[0] = 32'h00000008; d_ill[0] = 1'b0;
    d_instr[1] = 32'h00008067; d_ras[1] = 2'd2; d_imm[1] = 32'h00000000; d_ill[1] = 1'b0;
    d_instr[2] = 32'h000082E7; d_ras[2] = 2'd3; d_imm[2] = 32'h00000000; d_ill[2] = 1'b0;
    d_instr[3] = 32'h000080E7; d_ras[3] = 2'd1; d_imm[3] = 32'h00000000; d_ill[3] = 1'b0;
    d_instr[4] = 32'hFFDFF06F; d_ras[4] = 2'd0; d_imm[4] = 32'hFFFFFFFC; d_ill[4] = 1'b0;
    d_instr[5] = 32'h008000EC; d_ras[5] = 2'd0; d_imm[5] = 32'h00000000; d_ill[5] = 1'b1;

    bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ras_en", bus.ras_en, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1; bus.in_instr = d_instr[i]; bus.in_pc = 32'h100 + 32'(i * 4);
      bus.out_ready = 1;
      @(negedge clk);
      bus.in_valid = 0;
      #1;
      chk($sformatf("dir%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("dir%0d_ras", i), bus.out_ras_op, d_ras[i]);
      chk($sformatf("dir%0d_imm", i), bus.out_imm, d_imm[i]);
      chk($sformatf("dir%0d_pc", i), bus.out_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("dir%0d_ill", i), bus.out_illegal, d_ill[i]);
      chk($sformatf("dir%0d_ras_en", i), bus.ras_en, d_ras[i] != 0);
    end

    // Stall: three back-to-back offers with out_ready low, then release.
    @(negedge clk);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h200 + 32'(i * 4);
      @(negedge clk);
    end
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_out_pc", bus.out_pc, 32'h200);
    chk("stall_ras_en", bus.ras_en, 0);
    bus.out_ready = 1;
    #1;
    chk("rel_ras_en", bus.ras_en, 1);
    @(negedge clk);
    chk("rel_pc1", bus.out_pc, 32'h204);
    chk("rel_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 0;
    chk("rel_pc2", bus.out_pc, 32'h208);
    chk("rel_valid2", bus.out_valid, 1);
    @(negedge clk);
    chk("rel_drained", bus.out_valid, 0);

    // Flush with both entries held.
    bus.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h300 + 32'(i * 4);
      @(negedge clk);
    end
    bus.in_valid = 0;
    chk("pre_flush_in_ready", bus.in_ready, 0);
    bus.flush = 1; bus.out_ready = 1;
    #1;
    chk("flush_cycle_ras_en", bus.ras_en, 1);
    @(negedge clk);
    bus.flush = 0;
    #1;
    chk("post_flush_valid", bus.out_valid, 0);
    chk("post_flush_in_ready", bus.in_ready, 1);
    chk("post_flush_ras_en", bus.ras_en, 0);

    // Asynchronous reset mid-stall.
    bus.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h400 + 32'(i * 4);
      @(negedge clk);
    end
    bus.in_valid = 0; bus.out_ready = 1;
    #1;
    chk("pre_rst_ras_en", bus.ras_en, 1);
    rst_n = 0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    chk("async_rst_ras_en", bus.ras_en, 0);
    @(negedge clk);
    rst_n = 1;

    // Randomized phase against the queue model (capacity 2, FIFO).
    q.delete();
    pc_run = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_instr  = rnd_instr();
      bus.in_pc     = pc_run;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 99) < 3);
      #1;
      exp_rdy = (q.size() < 2);
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_out_valid", bus.out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("rnd_opcode", bus.out_opcode, q[0].op);
        chk("rnd_rd", bus.out_rd, q[0].rd);
        chk("rnd_rs1", bus.out_rs1, q[0].rs1);
        chk("rnd_imm", bus.out_imm, q[0].imm);
        chk("rnd_pc", bus.out_pc, q[0].pc);
        chk("rnd_ras_op", bus.out_ras_op, q[0].ras);
        chk("rnd_illegal", bus.out_illegal, q[0].ill);
        chk("rnd_ras_en", bus.ras_en, bus.out_ready && q[0].ras != 0);
      end else begin
        chk("rnd_ras_en_empty", bus.ras_en, 0);
      end
      acc  = bus.in_valid && exp_rdy;
      cons = (q.size() > 0) && bus.out_ready;
      @(posedge clk);
      if (bus.flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(ref_dec(bus.in_instr, bus.in_pc));
      end
      if (acc) pc_run = pc_run + 4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
